rx_bit_decoder: RTL and testbench
=================================

Name: rx_bit_decoder

Overview:
- Bit-level front stage of the USB RX path, directly upstream of the RX bit timer and shift register.
- Samples the synchronized D+/D- pair on each timer sample strobe and NRZI-decodes the line.
- Removes stuffed bits and reports each one on invalid_bit, so the timer can stretch the bit window.
- Detects start-of-packet edge, EOP (SE0,SE0,J) and line/stuff errors for the RX control unit.

Parameters:
- STUFF_LEN, 6, consecutive decoded 1s after which the next bit must be a stuffed 0.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- d_plus_sync  input  1  synchronized D+.
- d_minus_sync  input  1  synchronized D-.
- shift_enable  input  1  one-cycle sample strobe from the bit timer.
- enable  input  1  packet-active from RX control; low forces IDLE.
- d_edge  output  1  one-cycle pulse on D+ falling edge while in IDLE (SOP).
- d_orig  output  1  last decoded data bit; held between valid bits.
- bit_valid  output  1  one-cycle pulse: d_orig holds a new payload bit.
- invalid_bit  output  1  one-cycle pulse: sampled bit was a stuffed bit and was dropped.
- eop  output  1  one-cycle pulse on a correct SE0,SE0,J sequence.
- eop_err  output  1  one-cycle pulse on a malformed EOP.
- stuff_err  output  1  one-cycle pulse: 1 received where a stuffed 0 was required.
- line_err  output  1  one-cycle pulse: SE1 (D+=D-=1) sampled.

Behaviour:
- All outputs are registered.
- Reset values:
  - d_orig=1; all pulse outputs=0.
  - State=IDLE, ones_cnt=0, prev_dp=1 (J), dp_q=1.
- Line state at a strobe: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- Latency: every strobe-driven output appears in the cycle after the strobe cycle.
- d_edge:
  - dp_q registers d_plus_sync every cycle.
  - d_edge=1 when state=IDLE and dp_q=1 and d_plus_sync=0.
  - Evaluated every cycle, independent of shift_enable.
- State machine (transitions and outputs act only on cycles with shift_enable=1, except the enable=0 override):
  - IDLE:
    - If enable=1, go to ACTIVE next cycle with ones_cnt=0 and prev_dp=1.
    - Strobes are ignored in IDLE.
  - ACTIVE, J or K sampled:
    - bit = (d_plus_sync == prev_dp); then prev_dp <= d_plus_sync.
    - If ones_cnt==STUFF_LEN and bit=0: invalid_bit=1, no bit_valid, ones_cnt<=0.
    - If ones_cnt==STUFF_LEN and bit=1: stuff_err=1, no bit_valid, ones_cnt<=0, stay ACTIVE.
    - Otherwise: d_orig<=bit, bit_valid=1; ones_cnt<=bit ? ones_cnt+1 : 0.
  - ACTIVE, SE0 sampled: go to SE0_1; no bit output; prev_dp unchanged.
  - ACTIVE, SE1 sampled: line_err=1, go to IDLE.
  - SE0_1:
    - SE0 sampled -> SE0_2.
    - Anything else -> eop_err=1, go to IDLE.
  - SE0_2:
    - J sampled -> eop=1, go to IDLE.
    - Anything else -> eop_err=1, go to IDLE.
- enable=0 in any non-IDLE state:
  - State<=IDLE and ones_cnt<=0 on the next edge.
  - This overrides a strobe in the same cycle: no pulse is generated.
- rst=1 overrides everything, including a simultaneous strobe.
- ones_cnt width: $clog2(STUFF_LEN+1); it never exceeds STUFF_LEN.
- At most one of bit_valid/invalid_bit/stuff_err/eop/eop_err/line_err is high in any cycle.

Decomposition:
- Shared package usb_rx_pkg holds:
  - line_state_t enum {LS_J, LS_K, LS_SE0, LS_SE1}.
  - decoder state_t enum {IDLE, ACTIVE, SE0_1, SE0_2}.
  - Constants J_DP=1, K_DP=0.
- One natural sub-module, rx_line_classify: purely combinational mapping of (d_plus_sync, d_minus_sync) to line_state_t. It is reused by the RX control unit.
- FSM, NRZI decode and stuff counter stay in rx_bit_decoder.

Test Plan:
- Reset then enable=1; strobe the sequence K,J,K,J,K,J,K,K (SYNC) -> bit_valid pulses eight times with d_orig = 0,0,0,0,0,0,0,1.
- After a prior bit with prev_dp=1: J x6 then K, strobed -> six bit_valid pulses with d_orig=1, then invalid_bit=1 and no bit_valid for the K; the next J yields bit 0.
- Seven consecutive unchanged states (J x7) after a 0 bit -> six bit_valid pulses, then stuff_err=1 on the 7th; state remains ACTIVE.
- In ACTIVE, strobe SE0, SE0, J -> eop=1 exactly one cycle after the third strobe; state IDLE; a subsequent strobe produces no pulses.
- SE0 then K -> eop_err=1, IDLE. Separately, SE1 in ACTIVE -> line_err=1.
- IDLE with dp toggled 1->0 -> d_edge=1 for one cycle. Deassert enable mid-packet together with a strobe -> no pulse, IDLE next cycle. Assert rst with a strobe -> all outputs at reset values.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared types and constants for the USB RX path.
//   line_state_t : classified D+/D- line state (J, K, SE0, SE1)
//   state_t      : bit decoder FSM states
//   J_DP / K_DP  : D+ level of the J and K line states
//   nrzi_decode  : NRZI rule, an unchanged line level decodes to a 1
// -----------------------------------------------------------------------------
package usb_rx_pkg;

   typedef enum logic [1:0] {
      LS_J   = 2'd0,
      LS_K   = 2'd1,
      LS_SE0 = 2'd2,
      LS_SE1 = 2'd3
   } line_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      SE0_1  = 2'd2,
      SE0_2  = 2'd3
   } state_t;

   localparam logic J_DP = 1'b1;
   localparam logic K_DP = 1'b0;

   // No transition on the line encodes a 1, a transition encodes a 0.
   function automatic logic nrzi_decode(input logic dp, input logic prev_dp);
      return (dp == prev_dp);
   endfunction

endpackage : usb_rx_pkg

// File: rtl/rx_line_classify.sv
// -----------------------------------------------------------------------------
// rx_line_classify
// Purely combinational mapping of the synchronized D+/D- pair to a line state.
// Shared with the RX control unit, which needs the same J/K/SE0/SE1 view.
// Ports:
//   d_plus_sync  : synchronized D+
//   d_minus_sync : synchronized D-
//   line_state   : J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1)
// -----------------------------------------------------------------------------
module rx_line_classify
   import usb_rx_pkg::*;
(
   input  logic        d_plus_sync,
   input  logic        d_minus_sync,
   output line_state_t line_state
);

   always_comb begin
      // NOTE: assign a default before the case so every path drives the
      // output; a missed branch would otherwise infer a latch.
      line_state = LS_SE1;
      case ({d_plus_sync, d_minus_sync})
         2'b10:   line_state = LS_J;
         2'b01:   line_state = LS_K;
         2'b00:   line_state = LS_SE0;
         default: line_state = LS_SE1;
      endcase
   end

endmodule : rx_line_classify

// File: rtl/rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// rx_bit_decoder
// Bit-level front stage of the USB RX path. On every bit-timer strobe it
// samples the line, NRZI-decodes it, drops stuffed bits and tracks EOP.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   d_plus_sync   : synchronized D+
//   d_minus_sync  : synchronized D-
//   shift_enable  : one-cycle sample strobe from the bit timer
//   enable        : packet active from RX control; low forces IDLE
//   d_edge        : pulse on a D+ falling edge while IDLE (start of packet)
//   d_orig        : last decoded payload bit, held between valid bits
//   bit_valid     : pulse, d_orig holds a new payload bit
//   invalid_bit   : pulse, the sampled bit was a stuffed 0 and was dropped
//   eop           : pulse on a correct SE0,SE0,J end of packet
//   eop_err       : pulse on a malformed end of packet
//   stuff_err     : pulse, a 1 arrived where a stuffed 0 was required
//   line_err      : pulse, SE1 sampled
// All outputs are registered and appear the cycle after the strobe.
// -----------------------------------------------------------------------------
module rx_bit_decoder
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus_sync,
   input  logic d_minus_sync,
   input  logic shift_enable,
   input  logic enable,
   output logic d_edge,
   output logic d_orig,
   output logic bit_valid,
   output logic invalid_bit,
   output logic eop,
   output logic eop_err,
   output logic stuff_err,
   output logic line_err
);

   localparam int                CNT_W     = $clog2(STUFF_LEN + 1);
   localparam logic [CNT_W-1:0]  STUFF_MAX = CNT_W'(STUFF_LEN);

   state_t            state;
   line_state_t       line_state;
   logic [CNT_W-1:0]  ones_cnt;
   logic              prev_dp;
   logic              dp_q;
   logic              rx_bit;

   rx_line_classify u_classify (
      .d_plus_sync  (d_plus_sync),
      .d_minus_sync (d_minus_sync),
      .line_state   (line_state)
   );

   // Decoded value of the current sample relative to the previous J/K level.
   assign rx_bit = nrzi_decode(d_plus_sync, prev_dp);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ones_cnt    <= '0;
         prev_dp     <= J_DP;
         dp_q        <= J_DP;
         d_edge      <= 1'b0;
         d_orig      <= 1'b1;
         bit_valid   <= 1'b0;
         invalid_bit <= 1'b0;
         eop         <= 1'b0;
         eop_err     <= 1'b0;
         stuff_err   <= 1'b0;
         line_err    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the values from before this edge regardless of statement order.
         dp_q        <= d_plus_sync;
         // SOP detection runs every cycle, not only on strobes.
         d_edge      <= (state == IDLE) && dp_q && !d_plus_sync;

         // Pulses default low; at most one branch below raises one of them.
         bit_valid   <= 1'b0;
         invalid_bit <= 1'b0;
         eop         <= 1'b0;
         eop_err     <= 1'b0;
         stuff_err   <= 1'b0;
         line_err    <= 1'b0;

         if (!enable && (state != IDLE)) begin
            // Dropping enable aborts the packet and masks any strobe this cycle.
            state    <= IDLE;
            ones_cnt <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (enable) begin
                     state    <= ACTIVE;
                     ones_cnt <= '0;
                     prev_dp  <= J_DP;
                  end
               end

               ACTIVE: begin
                  if (shift_enable) begin
                     unique case (line_state)
                        LS_J, LS_K: begin
                           prev_dp <= d_plus_sync;
                           if (ones_cnt == STUFF_MAX) begin
                              // This slot must carry the stuffed 0.
                              ones_cnt <= '0;
                              if (rx_bit) stuff_err   <= 1'b1;
                              else        invalid_bit <= 1'b1;
                           end else begin
                              d_orig    <= rx_bit;
                              bit_valid <= 1'b1;
                              ones_cnt  <= rx_bit ? ones_cnt + CNT_W'(1) : '0;
                           end
                        end
                        LS_SE0: begin
                           // Possible EOP start; prev_dp is kept as is.
                           state <= SE0_1;
                        end
                        LS_SE1: begin
                           line_err <= 1'b1;
                           state    <= IDLE;
                           ones_cnt <= '0;
                        end
                     endcase
                  end
               end

               SE0_1: begin
                  if (shift_enable) begin
                     if (line_state == LS_SE0) begin
                        state <= SE0_2;
                     end else begin
                        eop_err  <= 1'b1;
                        state    <= IDLE;
                        ones_cnt <= '0;
                     end
                  end
               end

               SE0_2: begin
                  if (shift_enable) begin
                     if (line_state == LS_J) eop     <= 1'b1;
                     else                    eop_err <= 1'b1;
                     state    <= IDLE;
                     ones_cnt <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule : rx_bit_decoder

// File: tb/tb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// tb_rx_bit_decoder
// Directed stimulus with a scoreboard: each strobe that should produce a pulse
// pushes the expected output snapshot and the cycle it must appear in; a
// monitor pops and compares whenever the DUT raises any pulse.
// -----------------------------------------------------------------------------
module tb_rx_bit_decoder;
   import usb_rx_pkg::*;

   typedef struct packed {
      logic d_edge;
      logic bit_valid;
      logic invalid_bit;
      logic stuff_err;
      logic eop;
      logic eop_err;
      logic line_err;
      logic d_orig;
   } obs_t;

   typedef struct {
      obs_t o;
      int   cyc;
   } exp_t;

   logic clk;
   logic rst;
   logic d_plus_sync;
   logic d_minus_sync;
   logic shift_enable;
   logic enable;
   logic d_edge, d_orig, bit_valid, invalid_bit, eop, eop_err, stuff_err, line_err;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t q[$];
   obs_t got;
   exp_t e;

   rx_bit_decoder #(.STUFF_LEN(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .d_plus_sync  (d_plus_sync),
      .d_minus_sync (d_minus_sync),
      .shift_enable (shift_enable),
      .enable       (enable),
      .d_edge       (d_edge),
      .d_orig       (d_orig),
      .bit_valid    (bit_valid),
      .invalid_bit  (invalid_bit),
      .eop          (eop),
      .eop_err      (eop_err),
      .stuff_err    (stuff_err),
      .line_err     (line_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic obs_t mk(input string k, input logic d);
      obs_t o;
      o = '0;
      o.d_orig = d;
      if      (k == "bv")  o.bit_valid   = 1'b1;
      else if (k == "inv") o.invalid_bit = 1'b1;
      else if (k == "stf") o.stuff_err   = 1'b1;
      else if (k == "eop") o.eop         = 1'b1;
      else if (k == "eer") o.eop_err     = 1'b1;
      else if (k == "ler") o.line_err    = 1'b1;
      else if (k == "edg") o.d_edge      = 1'b1;
      return o;
   endfunction

   // Expectation for the output register update at the next edge.
   task automatic expect_next(input string k, input logic d);
      exp_t x;
      x.o   = mk(k, d);
      x.cyc = cyc + 1;
      q.push_back(x);
   endtask

   task automatic set_line(input line_state_t ls);
      case (ls)
         LS_J:    {d_plus_sync, d_minus_sync} = 2'b10;
         LS_K:    {d_plus_sync, d_minus_sync} = 2'b01;
         LS_SE0:  {d_plus_sync, d_minus_sync} = 2'b00;
         default: {d_plus_sync, d_minus_sync} = 2'b11;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One strobe; k=="" means no pulse is expected from it.
   task automatic sb(input line_state_t ls, input string k, input logic d);
      set_line(ls);
      shift_enable = 1'b1;
      if (k != "") expect_next(k, d);
      @(posedge clk);
      #1;
      shift_enable = 1'b0;
   endtask

   task automatic sbg(input line_state_t ls, input string k, input logic d);
      sb(ls, k, d);
      idle(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_d_orig"},      d_orig,      1);
      check({tag, "_d_edge"},      d_edge,      0);
      check({tag, "_bit_valid"},   bit_valid,   0);
      check({tag, "_invalid_bit"}, invalid_bit, 0);
      check({tag, "_stuff_err"},   stuff_err,   0);
      check({tag, "_eop"},         eop,         0);
      check({tag, "_eop_err"},     eop_err,     0);
      check({tag, "_line_err"},    line_err,    0);
   endtask

   // Monitor: any pulse must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         got = '{d_edge, bit_valid, invalid_bit, stuff_err, eop, eop_err, line_err, d_orig};
         if (got[7:1] != 7'd0) begin
            n_checks++;
            if (q.size() == 0) begin
               n_errors++;
               $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", got, cyc);
            end else begin
               e = q.pop_front();
               if (got !== e.o || cyc != e.cyc) begin
                  n_errors++;
                  $display("FAIL pulse_match: got %b at cycle %0d, expected %b at cycle %0d",
                           got, cyc, e.o, e.cyc);
               end
            end
         end
      end
   end

   line_state_t sync_ls[8] = '{LS_K, LS_J, LS_K, LS_J, LS_K, LS_J, LS_K, LS_K};
   logic        sync_b [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      shift_enable = 1'b0;
      set_line(LS_J);
      idle(3);
      check_reset_outputs("reset");
      rst = 1'b0;

      // SYNC pattern decodes to 0000_0001.
      enable = 1'b1;
      idle(1);
      for (int i = 0; i < 8; i++) sbg(sync_ls[i], "bv", sync_b[i]);

      // Bit 0 leaves prev_dp=J, six 1s, then the stuffed 0 is dropped.
      sbg(LS_J, "bv", 1'b0);
      for (int i = 0; i < 6; i++) sbg(LS_J, "bv", 1'b1);
      sbg(LS_K, "inv", 1'b1);
      sbg(LS_J, "bv", 1'b0);

      // Seven unchanged states: six 1s then a stuff error, still ACTIVE.
      for (int i = 0; i < 6; i++) sbg(LS_J, "bv", 1'b1);
      sbg(LS_J, "stf", 1'b1);
      sbg(LS_K, "bv", 1'b0);

      // Good EOP, then a strobe in IDLE only yields the D+ falling edge.
      sbg(LS_SE0, "", 1'b0);
      sbg(LS_SE0, "", 1'b0);
      sb(LS_J, "eop", 1'b0);
      enable = 1'b0;
      idle(1);
      sbg(LS_K, "edg", 1'b0);

      // Malformed EOP: SE0 then K.
      enable = 1'b1;
      idle(1);
      sbg(LS_SE0, "", 1'b0);
      sb(LS_K, "eer", 1'b0);
      enable = 1'b0;
      idle(1);

      // SE1 during a packet.
      enable = 1'b1;
      idle(1);
      sbg(LS_J, "bv", 1'b1);
      sb(LS_SE1, "ler", 1'b1);
      enable = 1'b0;
      idle(1);

      // SOP edge detection in IDLE without a strobe.
      set_line(LS_J);
      idle(1);
      set_line(LS_K);
      expect_next("edg", 1'b1);
      idle(2);

      // enable drop together with a strobe: no pulse, then IDLE (edge seen).
      set_line(LS_J);
      enable = 1'b1;
      idle(1);
      sbg(LS_K, "bv", 1'b0);
      enable = 1'b0;
      sbg(LS_J, "", 1'b0);
      set_line(LS_K);
      expect_next("edg", 1'b0);
      idle(2);

      // Reset together with a strobe wins over the strobe.
      enable = 1'b1;
      idle(1);
      sbg(LS_K, "bv", 1'b0);
      rst = 1'b1;
      set_line(LS_J);
      shift_enable = 1'b1;
      @(posedge clk);
      #1;
      shift_enable = 1'b0;
      enable = 1'b0;
      check_reset_outputs("rst_strobe");
      idle(1);
      rst = 1'b0;
      enable = 1'b1;
      idle(1);
      sbg(LS_J, "bv", 1'b1);

      idle(3);
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_rx_bit_decoder
